// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the chunked magnitude comparator:
//   - state_t     : controller states (IDLE, RUN, DONE)
//   - result_t    : one-hot result vector ordered {great, equal, less}
//   - clog2_min1  : ceil(log2(n)) clamped to at least 1, used for index widths
// -----------------------------------------------------------------------------
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Result vector bit order matches the {great, equal, less} output ports.
  typedef logic [2:0] result_t;

  localparam result_t RES_NONE  = 3'b000;
  localparam result_t RES_GREAT = 3'b100;
  localparam result_t RES_EQUAL = 3'b010;
  localparam result_t RES_LESS  = 3'b001;

  // A single-slice comparator still needs a 1-bit index port.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// -----------------------------------------------------------------------------
// cmp_slice
// Purely combinational unsigned comparator for one CHUNK-bit slice.
// Ports:
//   i_a, i_b : slice operands
//   o_g      : i_a >  i_b
//   o_e      : i_a == i_b
//   o_l      : i_a <  i_b
// Exactly one of o_g/o_e/o_l is high for any input pair.
// -----------------------------------------------------------------------------
module cmp_slice
  import cmp_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_g,
  output logic             o_e,
  output logic             o_l
);

  assign o_g = (i_a >  i_b);
  assign o_e = (i_a == i_b);
  assign o_l = (i_a <  i_b);

endmodule

// File: rtl/cmp_chunked.sv
// -----------------------------------------------------------------------------
// cmp_chunked
// Multi-cycle magnitude comparator for WIDTH-bit operands. After a pair is
// accepted, one CHUNK-bit slice is compared per cycle, most significant slice
// first, stopping at the first slice that differs. The one-hot result is held
// until the consumer takes it.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_valid     : operand pair offered        in_ready  : high only in IDLE
//   A, B         : operands                    signed_mode : 1 = two's complement
//   out_valid    : result held (DONE only)     out_ready : consumer takes result
//   great/equal/less : one-hot result, all 0 outside DONE
//   diff_idx     : first differing slice (NCHUNK-1 = MS slice), 0 when equal
//   busy         : controller is not IDLE
// WIDTH must be a multiple of CHUNK.
// -----------------------------------------------------------------------------
module cmp_chunked
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int IW     = clog2_min1(NCHUNK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             great,
  output logic             equal,
  output logic             less,
  output logic [IW-1:0]    diff_idx,
  output logic             busy
);

  localparam logic [IW-1:0]    IDX_TOP  = IW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = WIDTH'(1) << (WIDTH - 1);

  state_t           r_state,    w_state_nxt;
  logic [WIDTH-1:0] r_a,        w_a_nxt;
  logic [WIDTH-1:0] r_b,        w_b_nxt;
  logic [IW-1:0]    r_idx,      w_idx_nxt;
  logic [IW-1:0]    r_diff_idx, w_diff_idx_nxt;
  result_t          r_res,      w_res_nxt;

  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic             w_g;
  logic             w_e;
  logic             w_l;

  // Slice mux: bring slice r_idx down to bit 0 and keep the low CHUNK bits.
  assign w_a_slice = CHUNK'(r_a >> (r_idx * CHUNK));
  assign w_b_slice = CHUNK'(r_b >> (r_idx * CHUNK));

  cmp_slice #(.CHUNK(CHUNK)) u_slice (
    .i_a (w_a_slice),
    .i_b (w_b_slice),
    .o_g (w_g),
    .o_e (w_e),
    .o_l (w_l)
  );

  always_comb begin
    // NOTE: every next-state value is given its hold value first, so no branch
    // leaves one unassigned and no latch is inferred.
    w_state_nxt    = r_state;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_idx_nxt      = r_idx;
    w_res_nxt      = r_res;
    w_diff_idx_nxt = r_diff_idx;

    unique case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          // Flipping the sign bit of both operands (offset binary) lets the
          // unsigned slice compare produce the two's-complement ordering.
          w_a_nxt     = A ^ (signed_mode ? SIGN_BIT : '0);
          w_b_nxt     = B ^ (signed_mode ? SIGN_BIT : '0);
          w_idx_nxt   = IDX_TOP;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // A differing slice decides the result; an equal slice at index 0
        // means the operands are equal. Either way the slice comparator's
        // one-hot {g, e, l} is the final result and r_idx is the index.
        if (!w_e || (r_idx == '0)) begin
          w_res_nxt      = {w_g, w_e, w_l};
          w_diff_idx_nxt = r_idx;
          w_state_nxt    = ST_DONE;
        end else begin
          w_idx_nxt = r_idx - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_res_nxt      = RES_NONE;
          w_diff_idx_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= IDX_TOP;
      r_res      <= RES_NONE;
      r_diff_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_res      <= w_res_nxt;
      r_diff_idx <= w_diff_idx_nxt;
    end
  end

  // NOTE: the operand registers are deliberately left without reset; they are
  // always loaded at acceptance before any slice of them is examined.
  always_ff @(posedge clk) begin
    r_a <= w_a_nxt;
    r_b <= w_b_nxt;
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign great     = r_res[2];
  assign equal     = r_res[1];
  assign less      = r_res[0];
  assign diff_idx  = r_diff_idx;

endmodule

// File: tb/tb_cmp_chunked.sv
// -----------------------------------------------------------------------------
// tb_cmp_chunked
// Scoreboard bench for cmp_chunked. Four configurations run side by side:
//   16/4 (directed cases, reset abort, then random), 4/1, 32/8 and 8/8
//   (single slice). Each driver pushes the expected result, first differing
//   slice and latency into a queue at acceptance; an independent monitor pops
//   and compares whenever out_valid is seen, with randomised out_ready stalls.
// The reference works on whole integers: signed/unsigned value compare, and
// the highest slice in which the operands differ.
// -----------------------------------------------------------------------------
module tb_cmp_chunked;

  localparam int NCFG = 4;
  localparam int CFG_W [NCFG] = '{16, 4, 32, 8};
  localparam int CFG_C [NCFG] = '{4, 1, 8, 8};

  typedef struct {
    logic [2:0] res;   // {great, equal, less}
    int         diff;
    int         lat;
    int         acc;   // clock edge number of acceptance
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [NCFG-1:0] done_vec;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W  = CFG_W[g];
    localparam int C  = CFG_C[g];
    localparam int N  = W / C;
    localparam int IW = (N <= 1) ? 1 : $clog2(N);

    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          sm        = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a_in      = '0;
    logic [W-1:0]  b_in      = '0;
    logic          in_ready, out_valid, great, equal, less, busy;
    logic [IW-1:0] diff_idx;

    exp_t          q[$];
    bit            seen      = 1'b0;
    bit            exp_busy;
    bit            done      = 1'b0;
    int            force_hold = -1;
    int            waits;
    int            hold_req;
    logic [IW+2:0] held;
    exp_t          e_mon;

    assign done_vec[g] = done;

    cmp_chunked #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .A           (a_in),
      .B           (b_in),
      .signed_mode (sm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .great       (great),
      .equal       (equal),
      .less        (less),
      .diff_idx    (diff_idx),
      .busy        (busy)
    );

    function automatic longint to_int(input logic [W-1:0] x, input bit s);
      if (s && x[W-1]) return longint'(x) - (longint'(1) << W);
      return longint'(x);
    endfunction

    function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      for (int i = N - 1; i >= 0; i--) begin
        d = (x ^ y) >> (i * C);
        if (d[C-1:0] != '0) return i;
      end
      return -1;
    endfunction

    task automatic start();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("cfg%0d reset in_ready", g), in_ready, 1);
      check($sformatf("cfg%0d reset out_valid", g), out_valid, 0);
      check($sformatf("cfg%0d reset busy", g), busy, 0);
      check($sformatf("cfg%0d reset result", g), {great, equal, less}, 0);
      check($sformatf("cfg%0d reset diff_idx", g), diff_idx, 0);
      rst = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
      exp_t   e;
      longint sa, sb;
      int     d, t;
      @(negedge clk);
      a_in = a; b_in = b; sm = s; in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("cfg%0d accept", g), in_ready, 1);
      if (!in_ready) begin
        in_valid = 1'b0;
        return;
      end
      sa = to_int(a, s);
      sb = to_int(b, s);
      d  = first_diff(a, b);
      e.res  = (sa > sb) ? 3'b100 : (sa == sb) ? 3'b010 : 3'b001;
      e.diff = (d < 0) ? 0 : d;
      e.lat  = (d < 0) ? N : N - d;
      @(posedge clk);
      #1;
      e.acc = cyc;
      q.push_back(e);
      // Scramble the inputs: they must have no effect once accepted.
      in_valid = 1'b0;
      a_in = W'($urandom);
      b_in = W'($urandom);
      sm   = 1'($urandom);
    endtask

    task automatic wait_idle();
      int t = 0;
      while ((q.size() != 0 || seen) && t < 300) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("cfg%0d drained", g), (q.size() == 0) && !seen, 1);
    endtask

    task automatic sweep(input int n);
      for (int i = 0; i < n; i++) begin
        logic [W-1:0] a, b;
        a = W'($urandom);
        case ($urandom_range(0, 3))
          0:       b = a;
          1:       b = a ^ (W'(1) << $urandom_range(0, W - 1));
          default: b = W'($urandom);
        endcase
        send(a, b, 1'($urandom));
        if ($urandom_range(0, 2) == 0) wait_idle();
      end
      wait_idle();
    endtask

    // Monitor: owns out_ready, pops the scoreboard on each new result.
    always @(negedge clk) begin
      if (rst) begin
        seen      = 1'b0;
        out_ready = 1'b0;
      end else begin
        exp_busy = (q.size() != 0) || seen;
        check($sformatf("cfg%0d in_ready", g), in_ready, !exp_busy);
        check($sformatf("cfg%0d busy", g), busy, exp_busy);
        if (out_valid) begin
          check($sformatf("cfg%0d onehot", g), $countones({great, equal, less}), 1);
          if (!seen) begin
            if (q.size() == 0) begin
              check($sformatf("cfg%0d spurious out_valid", g), out_valid, 0);
            end else begin
              e_mon = q.pop_front();
              check($sformatf("cfg%0d result", g), {great, equal, less}, e_mon.res);
              check($sformatf("cfg%0d diff_idx", g), diff_idx, e_mon.diff);
              check($sformatf("cfg%0d latency", g), cyc - e_mon.acc, e_mon.lat);
            end
            held     = {great, equal, less, diff_idx};
            seen     = 1'b1;
            waits    = 0;
            hold_req = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 2));
          end else begin
            check($sformatf("cfg%0d stable", g), {great, equal, less, diff_idx}, held);
          end
          out_ready = (waits >= hold_req);
          waits++;
          if (out_ready) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            seen      = 1'b0;
          end
        end else begin
          check($sformatf("cfg%0d idle result", g), {great, equal, less}, 0);
        end
      end
    end

    if (g == 0) begin : g_dir
      initial begin
        start();
        send(16'hF000, 16'h0FFF, 1'b0);   // MS slice differs: latency 1
        wait_idle();
        send(16'h1234, 16'h1234, 1'b0);   // equal: latency 4
        wait_idle();
        send(16'h8000, 16'h0001, 1'b0);   // unsigned: great
        send(16'h8000, 16'h0001, 1'b1);   // signed: less
        wait_idle();
        force_hold = 5;
        send(16'h12A4, 16'h12B4, 1'b0);   // slice 1 differs, consumer stalls
        wait_idle();
        force_hold = -1;

        // Abort mid-RUN: reset sampled at the end of the second RUN cycle.
        send(16'h1234, 16'h1234, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        check("abort in_ready", in_ready, 1);
        check("abort busy", busy, 0);
        check("abort out_valid", out_valid, 0);
        check("abort result", {great, equal, less}, 0);
        check("abort diff_idx", diff_idx, 0);
        repeat (N + 3) @(negedge clk);
        send(16'hF000, 16'h0FFF, 1'b0);
        wait_idle();

        sweep(40);
        done = 1'b1;
      end
    end else begin : g_rnd
      initial begin
        start();
        sweep(60);
        done = 1'b1;
      end
    end
  end

  initial begin
    int t = 0;
    while (done_vec != {NCFG{1'b1}} && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check("all configs finished", done_vec, {NCFG{1'b1}});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
